// File: rtl/lfsr_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_run_ctrl
// Description : Run-length controller for an external LFSR datapath. The
//               controller accepts a host command (mode, tap mask, step
//               count). It resets the datapath for one cycle and then steps
//               it cmd_count times. Stepping stalls while pause is high. A
//               run aborts early with lockup set if the datapath reports an
//               all-zero state. A one-cycle done pulse ends each run and
//               captures the final datapath value.
// Ports       : clk, reset      - clock, synchronous active-high reset
//               cmd_*           - valid/ready command channel
//               pause           - stall stepping while high
//               lfsr_*          - control to / state from the LFSR datapath
//               busy, done      - status; done is a one-cycle pulse
//               lockup          - last run aborted on an all-zero state
//               last_value      - lfsr_out captured in the DONE cycle
//               signature       - rotate-XOR signature of the run
//                                 (only with LFSR_RUN_CTRL_SIG_EN)
// Options     : define LFSR_RUN_CTRL_SIG_EN to add the signature output
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_run_ctrl #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_mode,
  input  logic [WIDTH-1:0] cmd_taps,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             pause,
  output logic             lfsr_reset,
  output logic             lfsr_enable,
  output logic             lfsr_use_config,
  output logic [WIDTH-1:0] lfsr_taps,
  input  logic [WIDTH-1:0] lfsr_out,
  output logic             busy,
  output logic             done,
  output logic             lockup,
`ifdef LFSR_RUN_CTRL_SIG_EN
  output logic [WIDTH-1:0] last_value,
  output logic [WIDTH-1:0] signature
`else
  output logic [WIDTH-1:0] last_value
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             use_cfg_q, use_cfg_d;
  logic [WIDTH-1:0] taps_q, taps_d;
  logic             lockup_q, lockup_d;
  logic [WIDTH-1:0] last_q, last_d;

  // Status flags are registered decodes of the next state, so every status
  // output comes straight from a flop.
  logic             ready_q;
  logic             busy_q;
  logic             done_q;
  logic             load_q;
  logic             run_q;

  logic             accept;
  logic             step;

  assign accept = ready_q & cmd_valid;
  // Pause has to stall the datapath in the same cycle it is raised, so the
  // enable is the registered RUN flag gated by the live pause input.
  assign step   = run_q & ~pause;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    use_cfg_d = use_cfg_q;
    taps_d    = taps_q;
    lockup_d  = lockup_q;
    last_d    = last_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          use_cfg_d = cmd_mode;
          taps_d    = cmd_taps;
          cnt_d     = cmd_count;
          lockup_d  = 1'b0;
          state_d   = S_LOAD;
        end
      end

      S_LOAD: begin
        state_d = (cnt_q == '0) ? S_DONE : S_RUN;
      end

      S_RUN: begin
        if (step) begin
          cnt_d = cnt_q - c_cnt_one;
          // An all-zero state never leaves zero, so abandon the run at once.
          if (lfsr_out == '0) begin
            lockup_d = 1'b1;
            state_d  = S_DONE;
          end else if (cnt_q == c_cnt_one) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        last_d  = lfsr_out;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      use_cfg_q <= 1'b0;
      taps_q    <= '0;
      lockup_q  <= 1'b0;
      last_q    <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      load_q    <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      use_cfg_q <= use_cfg_d;
      taps_q    <= taps_d;
      lockup_q  <= lockup_d;
      last_q    <= last_d;
      ready_q   <= (state_d == S_IDLE);
      busy_q    <= (state_d != S_IDLE);
      done_q    <= (state_d == S_DONE);
      load_q    <= (state_d == S_LOAD);
      run_q     <= (state_d == S_RUN);
    end
  end

`ifdef LFSR_RUN_CTRL_SIG_EN
  // --------------------------------------------------------------------------
  // Run signature: rotate left by one, then fold in the datapath state on
  // every enabled RUN cycle.
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (accept) begin
      sig_d = '0;
    end else if (step) begin
      sig_d = {sig_q[WIDTH-2:0], sig_q[WIDTH-1]} ^ lfsr_out;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign signature = sig_q;
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // The datapath follows the controller reset directly, so both come out of
  // reset together.
  assign lfsr_reset      = reset | load_q;
  assign lfsr_enable     = step;
  assign lfsr_use_config = use_cfg_q;
  assign lfsr_taps       = taps_q;
  assign cmd_ready       = ready_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign lockup          = lockup_q;
  assign last_value      = last_q;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lfsr_run_ctrl
// Description : Self-checking bench for lfsr_run_ctrl (WIDTH=3, CNT_W=8).
//               A small LFSR datapath model closes the loop. A per-cycle
//               behavioural model, which tracks cycles since accept and
//               steps taken, checks every output. Directed runs pin the
//               model with literal cycle numbers, and a random phase
//               follows them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_run_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_mode;
  logic [2:0] cmd_taps;
  logic [7:0] cmd_count;
  logic       pause;
  logic       lfsr_reset;
  logic       lfsr_enable;
  logic       lfsr_use_config;
  logic [2:0] lfsr_taps;
  logic [2:0] lfsr_out;
  logic       busy;
  logic       done;
  logic       lockup;
  logic [2:0] last_value;
`ifdef LFSR_RUN_CTRL_SIG_EN
  logic [2:0] signature;
`endif

  always #5 clk = ~clk;

  lfsr_run_ctrl #(.WIDTH(3), .CNT_W(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_mode       (cmd_mode),
    .cmd_taps       (cmd_taps),
    .cmd_count      (cmd_count),
    .pause          (pause),
    .lfsr_reset     (lfsr_reset),
    .lfsr_enable    (lfsr_enable),
    .lfsr_use_config(lfsr_use_config),
    .lfsr_taps      (lfsr_taps),
    .lfsr_out       (lfsr_out),
    .busy           (busy),
    .done           (done),
    .lockup         (lockup),
`ifdef LFSR_RUN_CTRL_SIG_EN
    .last_value     (last_value),
    .signature      (signature)
`else
    .last_value     (last_value)
`endif
  );

  // Datapath model: Fibonacci shift register, seed 1 after reset. zap forces
  // the state to zero (visible at once and sticky until the next reset).
  logic       zap;
  logic [2:0] dp;
  logic [2:0] dp_taps;
  assign dp_taps  = lfsr_use_config ? lfsr_taps : 3'b110;
  assign lfsr_out = zap ? 3'b000 : dp;
  always @(posedge clk) begin
    if (lfsr_reset)       dp <= 3'b001;
    else if (zap)         dp <= 3'b000;
    else if (lfsr_enable) dp <= {dp[1:0], ^(dp & dp_taps)};
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model: m_age = cycles since accept (-1 when idle),
  // m_steps = enabled RUN cycles so far. A run ends when the steps reach the
  // count or an all-zero state is seen. The DONE cycle follows that point.
  // --------------------------------------------------------------------------
  bit         m_valid, m_lk, m_cfg, m_lockout;
  int         m_age, m_n, m_steps;
  logic [2:0] m_taps, m_last, m_sig;
  bit         e_idle, e_end, e_run, e_dc;

  initial begin
    m_valid = 0; m_age = -1; m_n = 0; m_steps = 0; m_lk = 0;
    m_cfg = 0; m_lockout = 0; m_taps = '0; m_last = '0; m_sig = '0;
    forever begin
      @(negedge clk);
      e_idle = (m_age < 0);
      e_end  = (m_steps >= m_n) || m_lk;
      e_run  = !e_idle && (m_age >= 2) && !e_end;
      e_dc   = !e_idle && (m_age >= 2) && e_end;
      if (m_valid) begin
        chk("cmd_ready",       32'(cmd_ready),       32'(e_idle));
        chk("busy",            32'(busy),            32'(!e_idle));
        chk("done",            32'(done),            32'(e_dc));
        chk("lfsr_reset",      32'(lfsr_reset),      32'(reset || (m_age == 1)));
        chk("lfsr_enable",     32'(lfsr_enable),     32'(e_run && !pause));
        chk("lfsr_use_config", 32'(lfsr_use_config), 32'(m_cfg));
        chk("lfsr_taps",       32'(lfsr_taps),       32'(m_taps));
        chk("lockup",          32'(lockup),          32'(m_lockout));
        chk("last_value",      32'(last_value),      32'(m_last));
`ifdef LFSR_RUN_CTRL_SIG_EN
        chk("signature",       32'(signature),       32'(m_sig));
`endif
      end
      if (reset) begin
        m_valid = 1; m_age = -1; m_lk = 0; m_cfg = 0; m_lockout = 0;
        m_taps = '0; m_last = '0; m_sig = '0; m_steps = 0; m_n = 0;
      end else if (m_valid) begin
        if (e_idle) begin
          if (cmd_valid) begin
            m_age = 1; m_n = int'(cmd_count); m_steps = 0; m_lk = 0;
            m_cfg = cmd_mode; m_taps = cmd_taps; m_lockout = 0; m_sig = '0;
          end
        end else if (e_dc) begin
          m_last = lfsr_out;
          m_age  = -1;
        end else begin
          if (e_run && !pause) begin
            m_sig = {m_sig[1:0], m_sig[2]} ^ lfsr_out;
            if (lfsr_out == 3'b000) begin
              m_lk = 1; m_lockout = 1;
            end else begin
              m_steps++;
            end
          end
          m_age++;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Directed run: accept in cycle 0, then observe cycles 1..ncyc.
  // --------------------------------------------------------------------------
  int   lr_at, first_en, last_en, en_cnt, done_at, dcount, first_ready, acc2;
  logic lock_r1;

  task automatic run_cmd(input bit mode, input logic [2:0] taps, input logic [7:0] cnt,
                         input int p_from, input int p_len, input int zap_at,
                         input int rst_at, input bit hold, input int ncyc);
    lr_at = -1; first_en = -1; last_en = -1; en_cnt = 0; done_at = -1;
    dcount = 0; first_ready = -1; acc2 = -1; lock_r1 = 1'bx;
    cmd_valid = 1'b1; cmd_mode = mode; cmd_taps = taps; cmd_count = cnt;
    pause = 1'b0; zap = 1'b0;
    @(posedge clk); #1;
    cmd_valid = hold;
    for (int r = 1; r <= ncyc; r++) begin
      pause = (r >= p_from) && (r < p_from + p_len);
      zap   = (r == zap_at);
      reset = (r == rst_at);
      @(negedge clk);
      if (lfsr_reset && lr_at < 0) lr_at = r;
      if (lfsr_enable) begin
        en_cnt++;
        if (first_en < 0) first_en = r;
        last_en = r;
      end
      if (done) begin
        dcount++;
        if (done_at < 0) done_at = r;
      end
      if (cmd_ready && first_ready < 0) first_ready = r;
      if (cmd_ready && cmd_valid && acc2 < 0) acc2 = r;
      if (r == 1) lock_r1 = lockup;
      @(posedge clk); #1;
      if (acc2 >= 0) cmd_valid = 1'b0;
    end
    pause = 1'b0; zap = 1'b0; reset = 1'b0; cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while (!cmd_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("wait_idle", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_mode = 1'b0; cmd_taps = '0;
    cmd_count = '0; pause = 1'b0; zap = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_lfsr_reset", 32'(lfsr_reset), 32'd1);
    chk("rst_busy",       32'(busy),       32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rv_cmd_ready", 32'(cmd_ready),       32'd1);
    chk("rv_done",      32'(done),            32'd0);
    chk("rv_lockup",    32'(lockup),          32'd0);
    chk("rv_enable",    32'(lfsr_enable),     32'd0);
    chk("rv_use_cfg",   32'(lfsr_use_config), 32'd0);
    chk("rv_taps",      32'(lfsr_taps),       32'd0);
    chk("rv_last",      32'(last_value),      32'd0);
    chk("rv_lreset",    32'(lfsr_reset),      32'd0);
    @(posedge clk); #1;

    // Basic run: mode 1, taps 110, count 5.
    run_cmd(1'b1, 3'b110, 8'd5, 0, 0, 0, 0, 1'b0, 9);
    chk("t1_lreset_at",  32'(lr_at),       32'd1);
    chk("t1_first_en",   32'(first_en),    32'd2);
    chk("t1_last_en",    32'(last_en),     32'd6);
    chk("t1_en_cnt",     32'(en_cnt),      32'd5);
    chk("t1_done_at",    32'(done_at),     32'd7);
    chk("t1_done_cnt",   32'(dcount),      32'd1);
    chk("t1_ready_at",   32'(first_ready), 32'd8);
    chk("t1_taps",       32'(lfsr_taps),   32'd6);
    chk("t1_use_cfg",    32'(lfsr_use_config), 32'd1);

    // Zero count: LOAD then DONE, no enables.
    wait_idle();
    run_cmd(1'b0, 3'b011, 8'd0, 0, 0, 0, 0, 1'b0, 4);
    chk("t2_lreset_at", 32'(lr_at),   32'd1);
    chk("t2_en_cnt",    32'(en_cnt),  32'd0);
    chk("t2_done_at",   32'(done_at), 32'd2);

    // Pause for cycles 3..5 of a count-4 run.
    wait_idle();
    run_cmd(1'b1, 3'b101, 8'd4, 3, 3, 0, 0, 1'b0, 11);
    chk("t3_en_cnt",  32'(en_cnt),  32'd4);
    chk("t3_done_at", 32'(done_at), 32'd9);

    // Datapath forced to zero on the 2nd RUN cycle.
    wait_idle();
    run_cmd(1'b0, 3'b000, 8'd5, 0, 0, 3, 0, 1'b0, 6);
    chk("t4_done_at", 32'(done_at),    32'd4);
    chk("t4_lockup",  32'(lockup),     32'd1);
    chk("t4_last",    32'(last_value), 32'd0);
    wait_idle();
    run_cmd(1'b0, 3'b110, 8'd2, 0, 0, 0, 0, 1'b0, 5);
    chk("t4b_lock_r1", 32'(lock_r1), 32'd0);
    chk("t4b_done_at", 32'(done_at), 32'd4);
    chk("t4b_lockup",  32'(lockup),  32'd0);

    // Reset in the 3rd RUN cycle of a count-10 run.
    wait_idle();
    run_cmd(1'b1, 3'b101, 8'd10, 0, 0, 0, 4, 1'b0, 4);
    @(negedge clk);
    chk("t5_done_cnt", 32'(dcount),          32'd0);
    chk("t5_ready",    32'(cmd_ready),       32'd1);
    chk("t5_busy",     32'(busy),            32'd0);
    chk("t5_done",     32'(done),            32'd0);
    chk("t5_enable",   32'(lfsr_enable),     32'd0);
    chk("t5_use_cfg",  32'(lfsr_use_config), 32'd0);
    chk("t5_taps",     32'(lfsr_taps),       32'd0);
    chk("t5_last",     32'(last_value),      32'd0);
    chk("t5_lreset",   32'(lfsr_reset),      32'd0);
    @(posedge clk); #1;

    // cmd_valid held high: next accept only at cycle count+3.
    run_cmd(1'b1, 3'b110, 8'd5, 0, 0, 0, 0, 1'b1, 12);
    chk("t6_acc2",    32'(acc2),    32'd8);
    chk("t6_done_at", 32'(done_at), 32'd7);
    wait_idle();

    // Random phase, checked by the model every cycle.
    for (int i = 0; i < 2500; i++) begin
      reset     = ($urandom_range(0, 199) == 0);
      cmd_valid = ($urandom_range(0, 3) != 0);
      cmd_mode  = 1'($urandom_range(0, 1));
      cmd_taps  = 3'($urandom_range(0, 7));
      cmd_count = 8'($urandom_range(0, 12));
      pause     = ($urandom_range(0, 3) == 0);
      zap       = ($urandom_range(0, 24) == 0);
      @(posedge clk); #1;
    end
    reset = 1'b0; cmd_valid = 1'b0; pause = 1'b0; zap = 1'b0;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
